// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential Booth multiplier.
// Contents: operand width, iteration counts for both step widths, counter width,
// FSM state encoding, Booth recode opcodes and the recode function.
package seq_multiplier_pkg;
  localparam int WIDTH   = 32;
  localparam int ITER_R2 = 32;
  localparam int ITER_R4 = 16;
  localparam int CNT_W   = $clog2(ITER_R2);
  localparam int HI_W    = WIDTH + 1;  // accumulator high part, one bit wider than operands

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_ZERO = 3'd0,
    OP_ADD1 = 3'd1,
    OP_ADD2 = 3'd2,
    OP_SUB1 = 3'd3,
    OP_SUB2 = 3'd4
  } booth_op_t;

  // Radix-4 window {b[i+1], b[i], b[i-1]}. Radix-2 reuses it as {b[i], b[i], b[i-1]},
  // which only ever yields 0 / +1 / -1.
  function automatic booth_op_t booth_recode(input logic [2:0] w);
    case (w)
      3'b001, 3'b010: booth_recode = OP_ADD1;
      3'b011:         booth_recode = OP_ADD2;
      3'b100:         booth_recode = OP_SUB2;
      3'b101, 3'b110: booth_recode = OP_SUB1;
      default:        booth_recode = OP_ZERO;
    endcase
  endfunction
endpackage

// File: rtl/seq_multiplier_if.sv
// Start / operand / result bundle of the sequential multiplier.
// slave : multiplier side (takes start + operands, drives result, exception, ready)
// master: requester side
interface seq_multiplier_if;
  import seq_multiplier_pkg::*;
  logic             ctrl_MULT;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport slave  (input  ctrl_MULT, data_operandA, data_operandB,
                  output data_result, data_exception, data_resultRDY);
  modport master (output ctrl_MULT, data_operandA, data_operandB,
                  input  data_result, data_exception, data_resultRDY);
endinterface

// File: rtl/seq_multiplier_booth_step.sv
// One Booth step (combinational): adds 0, +-M or +-2M to the accumulator high part.
// Ports: hi (accumulator high part), mcand (multiplicand), recode (3-bit window),
//        hi_next (sum, SHIFT bits wider than hi so the caller can shift it down).
// Subtraction is inversion plus carry-in; the extra width keeps -(-2^31) and
// -2*(-2^31) exact.
module booth_step
  import seq_multiplier_pkg::*;
#(
  parameter int SHIFT = 1,
  parameter int SUM_W = HI_W + SHIFT
) (
  input  logic [HI_W-1:0]  hi,
  input  logic [WIDTH-1:0] mcand,
  input  logic [2:0]       recode,
  output logic [SUM_W-1:0] hi_next
);
  logic [SUM_W-1:0] hi_x, m_x, addend;
  logic             cin;

  always_comb begin
    hi_x   = {{SHIFT{hi[HI_W-1]}}, hi};
    m_x    = {{(SUM_W-WIDTH){mcand[WIDTH-1]}}, mcand};
    addend = '0;
    cin    = 1'b0;
    case (booth_recode(recode))
      OP_ADD1: addend = m_x;
      OP_ADD2: addend = m_x << 1;
      OP_SUB1: begin addend = ~m_x;        cin = 1'b1; end
      OP_SUB2: begin addend = ~(m_x << 1); cin = 1'b1; end
      default: ;
    endcase
    hi_next = hi_x + addend + SUM_W'(cin);
  end
endmodule

// File: rtl/seq_multiplier.sv
// Sequential signed 32x32 Booth multiplier.
// Ports: clock, reset (async, active high), bus (seq_multiplier_if.slave):
//   ctrl_MULT start pulse, data_operandA/B operands, data_result low product word,
//   data_exception product overflows 32 signed bits, data_resultRDY one-cycle done.
// Build option: MULT_RADIX4_BOOTH_EN selects radix-4 (16 steps) instead of
// radix-2 (32 steps); results are identical, only latency differs.
// A start while busy or done restarts with fresh operands and drops the old result.
module seq_multiplier
  import seq_multiplier_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  seq_multiplier_if.slave bus
);
`ifdef MULT_RADIX4_BOOTH_EN
  localparam int ITER  = ITER_R4;
  localparam int SHIFT = 2;
`else
  localparam int ITER  = ITER_R2;
  localparam int SHIFT = 1;
`endif
  localparam int SUM_W = HI_W + SHIFT;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  // accumulator = {hi, lo, guard}; lo starts as the multiplier and ends as the low product
  logic [HI_W-1:0]  hi;
  logic [WIDTH-1:0] lo;
  logic             guard;
  logic [2:0]       recode;
  logic [SUM_W-1:0] sum;
  logic             last, load, step_en, fire;
  logic [WIDTH:0]   top_bits;

`ifdef MULT_RADIX4_BOOTH_EN
  assign recode = {lo[1:0], guard};
`else
  assign recode = {lo[0], lo[0], guard};
`endif
  assign last = (cnt == CNT_W'(ITER - 1));

  booth_step #(.SHIFT(SHIFT)) u_step (
    .hi      (hi),
    .mcand   (mcand),
    .recode  (recode),
    .hi_next (sum)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (bus.ctrl_MULT) state_nx = ST_BUSY;
    else begin
      case (state)
        ST_IDLE: state_nx = ST_IDLE;
        ST_BUSY: if (last) state_nx = ST_DONE;
        ST_DONE: state_nx = ST_IDLE;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    load    = bus.ctrl_MULT;
    step_en = (state == ST_BUSY) && !bus.ctrl_MULT;
    fire    = (state == ST_DONE) && !bus.ctrl_MULT;
  end

  // Shift drops the sum's top SHIFT bits: they are pure sign copies because the
  // partial product always fits the 33+32-bit accumulator.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      guard <= 1'b0;
    end else if (load) begin
      cnt   <= '0;
      mcand <= bus.data_operandA;
      hi    <= '0;
      lo    <= bus.data_operandB;
      guard <= 1'b0;
    end else if (step_en) begin
      cnt   <= cnt + 1'b1;
      hi    <= sum[SHIFT +: HI_W];
      lo    <= {sum[SHIFT-1:0], lo[WIDTH-1:SHIFT]};
      guard <= lo[SHIFT-1];
    end
  end

  // product bits [63:31]; they must all match for the product to fit 32 signed bits
  assign top_bits = {hi[WIDTH-1:0], lo[WIDTH-1]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.data_result    <= '0;
      bus.data_exception <= 1'b0;
      bus.data_resultRDY <= 1'b0;
    end else begin
      bus.data_resultRDY <= fire;
      if (fire) begin
        bus.data_result    <= lo;
        bus.data_exception <= !((&top_bits) || !(|top_bits));
      end
    end
  end
endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed cases, restart, reset abort and
// randomized operands against a 64-bit arithmetic reference.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_seq_multiplier;
`ifdef MULT_RADIX4_BOOTH_EN
  localparam int ITER = 16;
`else
  localparam int ITER = 32;
`endif
  localparam longint PMAX = 64'sh000000007FFFFFFF;
  localparam longint PMIN = -64'sh0000000080000000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  seq_multiplier_if bus();

  seq_multiplier dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    r = p[31:0];
    e = (p > PMAX) || (p < PMIN);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: pick = 32'h80000000;
      1: pick = 32'h7FFFFFFF;
      2: pick = 32'h0;
      3: pick = 32'hFFFFFFFF;
      4: pick = $urandom_range(0, 31) - 32'd16;
      default: pick = $urandom;
    endcase
  endfunction

  // Called just after a falling edge. Start pulses at edges 0..hold-1 (only the last
  // carries a,b), optional restart at edge re_at with a2,b2; checks one ready pulse
  // at the right edge with the model's result, and that the result holds afterwards.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input int re_at,
                       input logic [31:0] a2, input logic [31:0] b2);
    int          s, cycles, pulses, at;
    logic [31:0] fa, fb, er, res;
    logic        ee, exc;
    s      = (re_at > 0) ? re_at : hold - 1;
    fa     = (re_at > 0) ? a2 : a;
    fb     = (re_at > 0) ? b2 : b;
    model(fa, fb, er, ee);
    cycles = s + ITER + 4;
    pulses = 0; at = -1; res = '0; exc = 1'b0;
    bus.ctrl_MULT     = 1'b1;
    bus.data_operandA = (hold == 1) ? a : $urandom;
    bus.data_operandB = (hold == 1) ? b : $urandom;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clock);
      if (bus.data_resultRDY) begin
        pulses++; at = k; res = bus.data_result; exc = bus.data_exception;
      end
      if (k + 1 == re_at) begin
        bus.ctrl_MULT = 1'b1; bus.data_operandA = a2; bus.data_operandB = b2;
      end else if (k + 1 < hold) begin
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = (k + 1 == hold - 1) ? a : $urandom;
        bus.data_operandB = (k + 1 == hold - 1) ? b : $urandom;
      end else begin
        bus.ctrl_MULT = 1'b0; bus.data_operandA = $urandom; bus.data_operandB = $urandom;
      end
    end
    chk({tag, ".pulses"}, 64'(pulses), 64'(1));
    chk({tag, ".edge"}, 64'(at), 64'(s + ITER + 1));
    chk({tag, ".result"}, 64'(res), 64'(er));
    chk({tag, ".exc"}, 64'(exc), 64'(ee));
    chk({tag, ".hold"}, 64'(bus.data_result), 64'(er));
  endtask

  initial begin
    int pulses;
    bus.ctrl_MULT = 1'b0; bus.data_operandA = '0; bus.data_operandB = '0;
    repeat (3) @(negedge clock);
    chk("rst.result", 64'(bus.data_result), 64'(0));
    chk("rst.exc", 64'(bus.data_exception), 64'(0));
    chk("rst.rdy", 64'(bus.data_resultRDY), 64'(0));
    reset = 1'b0;
    @(negedge clock);

    do_op("d3x5",   32'd3,          32'd5,          1, 0, '0, '0);
    do_op("dm7x6",  32'hFFFFFFF9,   32'd6,          1, 0, '0, '0);
    do_op("dm1xm1", 32'hFFFFFFFF,   32'hFFFFFFFF,   1, 0, '0, '0);
    do_op("dmaxx2", 32'h7FFFFFFF,   32'd2,          1, 0, '0, '0);
    do_op("dminxm1",32'h80000000,   32'hFFFFFFFF,   1, 0, '0, '0);
    do_op("dminxmin",32'h80000000,  32'h80000000,   1, 0, '0, '0);
    do_op("restart",32'd3,          32'd5,          1, 10, 32'd4, 32'd4);
    do_op("hold3",  32'h12345678,   32'hFFFF0001,   3, 0, '0, '0);

    // reset in the middle of an operation
    bus.ctrl_MULT = 1'b1; bus.data_operandA = 32'd9; bus.data_operandB = 32'd9;
    @(negedge clock);
    bus.ctrl_MULT = 1'b0;
    repeat (11) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrst.result", 64'(bus.data_result), 64'(0));
    chk("midrst.exc", 64'(bus.data_exception), 64'(0));
    chk("midrst.rdy", 64'(bus.data_resultRDY), 64'(0));
    repeat (2) @(negedge clock);
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (bus.data_resultRDY) pulses++;
    end
    chk("midrst.norsp", 64'(pulses), 64'(0));
    do_op("d2xm3", 32'd2, 32'hFFFFFFFD, 1, 0, '0, '0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b, a2, b2;
      int          mode;
      a = pick(); b = pick(); a2 = pick(); b2 = pick();
      mode = $urandom_range(0, 9);
      if (mode == 0)      do_op("rnd.hold", a, b, $urandom_range(2, 4), 0, '0, '0);
      else if (mode == 1) do_op("rnd.restart", a, b, 1, $urandom_range(1, ITER + 1), a2, b2);
      else                do_op("rnd", a, b, 1, 0, '0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
